// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared VGA timing definitions for the sync generator and the sync receiver.
//   - Default 640x480@60 segment lengths (horizontal in clocks, vertical in lines)
//   - Sync pulse polarity default
//   - Receiver FSM state encoding
//   - Saturating 11-bit increment used by the receiver counters
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int   H_ACTIVE_AREA = 640;
    localparam int   V_ACTIVE_AREA = 480;
    localparam int   H_TOTAL       = 800;
    localparam int   V_TOTAL       = 525;
    localparam int   H_SYNC        = 96;
    localparam int   H_BACK_PORCH  = 48;
    localparam int   H_FRONT_PORCH = 16;
    localparam int   V_SYNC        = 2;
    localparam int   V_BACK_PORCH  = 33;
    localparam int   V_FRONT_PORCH = 10;
    localparam logic SYNC_ACTIVE   = 1'b1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    // Counters stick at all-ones instead of wrapping, so a dead sync input
    // can never alias back into a plausible length.
    function automatic logic [10:0] sat_inc11(input logic [10:0] value);
        return (value == 11'h7FF) ? value : value + 11'd1;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// -----------------------------------------------------------------------------
// vga_sync_edge
// Polarity-aware leading-edge detector for a sync signal.
//   i_clk      pixel clock
//   i_reset_n  synchronous active-low reset
//   i_en       sample enable: the previous-sample flop only updates when high,
//              and an edge is only reported while high
//   i_sync     sync input, SYNC_ACTIVE during the pulse
//   o_edge     combinational: i_sync active now, previous enabled sample inactive
// The previous-sample flop resets to the active level so a sync line held
// active through reset release is not mistaken for a fresh edge.
// -----------------------------------------------------------------------------
module vga_sync_edge #(
    parameter logic SYNC_ACTIVE = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_en,
    input  logic i_sync,
    output logic o_edge
);

    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_prev <= SYNC_ACTIVE;
        end else if (i_en) begin
            r_prev <= i_sync;
        end
    end

    assign o_edge = i_en && (i_sync == SYNC_ACTIVE) && (r_prev != SYNC_ACTIVE);

endmodule

// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
// Aligns to an incoming hs/vs pair, verifies line and frame lengths, declares
// lock after one clean frame and regenerates active-area pixel coordinates.
//   i_clk         pixel clock
//   i_reset_n     synchronous active-low reset
//   i_hs, i_vs    sync inputs, SYNC_ACTIVE during the pulse
//   o_locked      timing verified, coordinates valid
//   o_lockLost    one-cycle pulse on each LOCKED -> SEARCH transition
//   o_activeArea  pixel inside the active window (locked only)
//   o_px, o_py    active-area coordinates, 0 outside the window
//   o_hLen        last measured line length (clocks)
//   o_vLen        last measured frame length (lines)
// Pipeline: stage 1 registers the line position (r_hCnt) and line number
// (r_lCnt) of each input sample together with the FSM state; stage 2 turns
// those into registered coordinates, giving a two-cycle coordinate latency.
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
    parameter int   H_ACTIVE_AREA = vga_timing_pkg::H_ACTIVE_AREA,
    parameter int   V_ACTIVE_AREA = vga_timing_pkg::V_ACTIVE_AREA,
    parameter int   H_TOTAL       = vga_timing_pkg::H_TOTAL,
    parameter int   V_TOTAL       = vga_timing_pkg::V_TOTAL,
    parameter int   H_SYNC        = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK_PORCH  = vga_timing_pkg::H_BACK_PORCH,
    parameter int   H_FRONT_PORCH = vga_timing_pkg::H_FRONT_PORCH,
    parameter int   V_SYNC        = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK_PORCH  = vga_timing_pkg::V_BACK_PORCH,
    parameter int   V_FRONT_PORCH = vga_timing_pkg::V_FRONT_PORCH,
    parameter logic SYNC_ACTIVE   = vga_timing_pkg::SYNC_ACTIVE
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic        o_locked,
    output logic        o_lockLost,
    output logic        o_activeArea,
    output logic [9:0]  o_px,
    output logic [9:0]  o_py,
    output logic [10:0] o_hLen,
    output logic [10:0] o_vLen
);

    import vga_timing_pkg::*;

    localparam logic [10:0] C_CNT_MAX = 11'h7FF;
    localparam logic [10:0] C_H_TOTAL = 11'(H_TOTAL);
    localparam logic [10:0] C_V_TOTAL = 11'(V_TOTAL);
    localparam logic [10:0] C_H_START = 11'(H_SYNC + H_BACK_PORCH);
    localparam logic [10:0] C_H_END   = 11'(H_TOTAL - H_FRONT_PORCH);
    localparam logic [10:0] C_H_ACT   = 11'(H_ACTIVE_AREA);
    localparam logic [10:0] C_V_START = 11'(V_SYNC + V_BACK_PORCH);
    localparam logic [10:0] C_V_END   = 11'(V_TOTAL - V_FRONT_PORCH);
    localparam logic [10:0] C_V_ACT   = 11'(V_ACTIVE_AREA);

    // ------------------------------------------------------------------
    // Edge detection. The vs detector is only clocked on hs edges, so its
    // "edge" is exactly a frame start: vs active at this hs edge but not at
    // the previous one. This tolerates vs leading or lagging hs by up to
    // one line minus one clock.
    // ------------------------------------------------------------------
    logic w_hsEdge;
    logic w_frameStart;

    vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_hs_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (1'b1),
        .i_sync    (i_hs),
        .o_edge    (w_hsEdge)
    );

    vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_vs_edge (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_hsEdge),
        .i_sync    (i_vs),
        .o_edge    (w_frameStart)
    );

    // ------------------------------------------------------------------
    // Position counters and length measurements (stage 1)
    // ------------------------------------------------------------------
    logic [10:0] r_hCnt;
    logic [10:0] r_lCnt;
    logic [10:0] w_hLenMeas;
    logic [10:0] w_vLenMeas;

    // Length of the line/frame that ends at the current edge: the last
    // position before the edge plus one.
    assign w_hLenMeas = sat_inc11(r_hCnt);
    assign w_vLenMeas = sat_inc11(r_lCnt);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_hCnt <= '0;
            r_lCnt <= '0;
            o_hLen <= '0;
            o_vLen <= '0;
        end else begin
            if (w_hsEdge) begin
                r_hCnt <= '0;
                o_hLen <= w_hLenMeas;
            end else begin
                r_hCnt <= w_hLenMeas;
            end

            if (w_frameStart) begin
                r_lCnt <= '0;
                o_vLen <= w_vLenMeas;
            end else if (w_hsEdge) begin
                r_lCnt <= w_vLenMeas;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lock FSM
    // ------------------------------------------------------------------
    rx_state_t r_state;
    rx_state_t w_stateNext;
    logic      w_lineErr;
    logic      w_frameOk;
    logic      w_watchdog;

    assign w_lineErr  = w_hsEdge && (w_hLenMeas != C_H_TOTAL);
    assign w_frameOk  = w_frameStart && (w_vLenMeas == C_V_TOTAL);
    assign w_watchdog = (r_hCnt == C_CNT_MAX);

    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            SEARCH: begin
                if (w_frameStart) begin
                    w_stateNext = MEASURE;
                end
            end
            MEASURE: begin
                // A bad line outranks a frame start landing on the same edge.
                if (w_lineErr) begin
                    w_stateNext = SEARCH;
                end else if (w_frameOk) begin
                    w_stateNext = LOCKED;
                end
            end
            LOCKED: begin
                if (w_lineErr || (w_frameStart && !w_frameOk)) begin
                    w_stateNext = SEARCH;
                end
            end
            default: begin
                w_stateNext = SEARCH;
            end
        endcase
        // hs has stopped toggling: drop whatever we believed.
        if (w_watchdog) begin
            w_stateNext = SEARCH;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= SEARCH;
            o_locked   <= 1'b0;
            o_lockLost <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            o_locked   <= (w_stateNext == LOCKED);
            o_lockLost <= (r_state == LOCKED) && (w_stateNext == SEARCH);
        end
    end

    // ------------------------------------------------------------------
    // Coordinate stage (stage 2). r_hCnt, r_lCnt and r_state all describe
    // the same input sample here.
    // ------------------------------------------------------------------
    logic [10:0] w_xOff;
    logic [10:0] w_yOff;
    logic        w_inH;
    logic        w_inV;
    logic        w_active;

    assign w_xOff = r_hCnt - C_H_START;
    assign w_yOff = r_lCnt - C_V_START;

    // The offset bound keeps the window no wider than the active area even
    // if the porch parameters are configured inconsistently.
    assign w_inH    = (r_hCnt >= C_H_START) && (r_hCnt < C_H_END) && (w_xOff < C_H_ACT);
    assign w_inV    = (r_lCnt >= C_V_START) && (r_lCnt < C_V_END) && (w_yOff < C_V_ACT);
    assign w_active = w_inH && w_inV && (r_state == LOCKED);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_activeArea <= 1'b0;
            o_px         <= '0;
            o_py         <= '0;
        end else begin
            o_activeArea <= w_active;
            o_px         <= w_active ? w_xOff[9:0] : 10'd0;
            o_py         <= w_active ? w_yOff[9:0] : 10'd0;
        end
    end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_receiver
// Directed bench for vga_sync_receiver using a scaled-down raster so several
// frames fit in a short run:
//   H: sync 4, back porch 3, active 16, front porch 2 -> 25 clocks/line,
//      active L in [7,23)
//   V: sync 2, back porch 3, active 8,  front porch 2 -> 15 lines/frame,
//      active lines in [5,13)
// A second instance runs with SYNC_ACTIVE=0 on the inverted stream.
// -----------------------------------------------------------------------------
module tb_vga_sync_receiver;

    localparam int HS  = 4;
    localparam int HBP = 3;
    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HT  = HS + HBP + HA + HFP;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VT  = VS + VBP + VA + VFP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic hs;
    logic vs;
    logic hs_n;
    logic vs_n;
    assign hs_n = ~hs;
    assign vs_n = ~vs;

    logic        p_locked, p_lost, p_act;
    logic [9:0]  p_px, p_py;
    logic [10:0] p_hlen, p_vlen;
    logic        n_locked, n_lost, n_act;
    logic [9:0]  n_px, n_py;
    logic [10:0] n_hlen, n_vlen;

    vga_sync_receiver #(
        .H_ACTIVE_AREA(HA), .V_ACTIVE_AREA(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_FRONT_PORCH(HFP),
        .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP),
        .SYNC_ACTIVE(1'b1)
    ) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_hs(hs), .i_vs(vs),
        .o_locked(p_locked), .o_lockLost(p_lost), .o_activeArea(p_act),
        .o_px(p_px), .o_py(p_py), .o_hLen(p_hlen), .o_vLen(p_vlen)
    );

    vga_sync_receiver #(
        .H_ACTIVE_AREA(HA), .V_ACTIVE_AREA(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_SYNC(HS), .H_BACK_PORCH(HBP), .H_FRONT_PORCH(HFP),
        .V_SYNC(VS), .V_BACK_PORCH(VBP), .V_FRONT_PORCH(VFP),
        .SYNC_ACTIVE(1'b0)
    ) u_dut_n (
        .i_clk(clk), .i_reset_n(rst_n), .i_hs(hs_n), .i_vs(vs_n),
        .o_locked(n_locked), .o_lockLost(n_lost), .o_activeArea(n_act),
        .o_px(n_px), .o_py(n_py), .o_hLen(n_hlen), .o_vLen(n_vlen)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // stream generator state: position of the next sample to drive
    int g_h         = 0;
    int g_v         = 0;
    int short_line  = -1;
    bit short_frame = 1'b0;
    bit kill_hs     = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive the current generator position for one clock, then advance.
    // Returns 1ns after the rising edge that sampled it.
    task automatic clk_gen();
        hs = (!kill_hs && (g_h < HS));
        vs = (g_v < VS);
        @(posedge clk);
        #1;
        g_h++;
        if (g_h >= ((g_v == short_line) ? HT - 1 : HT)) begin
            if (g_v == short_line) short_line = -1;
            g_h = 0;
            g_v++;
            if (g_v >= (short_frame ? VT - 1 : VT)) begin
                g_v = 0;
                short_frame = 1'b0;
            end
        end
    endtask

    // Clock the stream until (h,v) is the next sample to be driven.
    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!((g_h == h) && (g_v == v)) && (n < 20000)) begin
            clk_gen();
            n++;
        end
        chk("reach_position", {31'd0, (g_h == h) && (g_v == v)}, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        $display("%s: outputs after reset", tag);
        chk({tag, "_locked"}, p_locked, 0);
        chk({tag, "_lost"},   p_lost,   0);
        chk({tag, "_act"},    p_act,    0);
        chk({tag, "_px"},     p_px,     0);
        chk({tag, "_py"},     p_py,     0);
        chk({tag, "_hlen"},   p_hlen,   0);
        chk({tag, "_vlen"},   p_vlen,   0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        hs    = 1'b0;
        vs    = 1'b0;
        g_h   = 0;
        g_v   = 8;

        // ---------------- reset state ----------------
        repeat (3) clk_gen();
        chk_all_zero("reset");
        chk("reset_n_locked", n_locked, 0);
        rst_n = 1'b1;

        // ---------------- clean stream lock ----------------
        run_to(0, 0);
        clk_gen();                       // frame start #1
        $display("frame start 1: locked=%0d vlen=%0d", p_locked, p_vlen);
        chk("fs1_locked", p_locked, 0);
        chk("fs1_vlen_partial", p_vlen, 7);
        run_to(HT - 1, VT - 1);
        clk_gen();
        chk("pre_lock", p_locked, 0);
        clk_gen();                       // frame start #2
        $display("frame start 2: locked=%0d/%0d hlen=%0d vlen=%0d", p_locked, n_locked, p_hlen, p_vlen);
        chk("lock_rise", p_locked, 1);
        chk("lock_rise_inv", n_locked, 1);
        chk("hlen_clean", p_hlen, 25);
        chk("vlen_clean", p_vlen, 15);
        chk("hlen_clean_inv", n_hlen, 25);

        // first active pixel (7,5), two cycles latency
        run_to(7, 5);
        clk_gen();
        chk("before_first_px_act", p_act, 0);
        clk_gen();
        $display("pixel (7,5): act=%0d px=%0d py=%0d", p_act, p_px, p_py);
        chk("first_px_act", p_act, 1);
        chk("first_px_x", p_px, 0);
        chk("first_px_y", p_py, 0);
        chk("first_px_act_inv", n_act, 1);
        // last active pixel (22,12)
        run_to(22, 12);
        clk_gen();
        clk_gen();
        $display("pixel (22,12): act=%0d px=%0d py=%0d", p_act, p_px, p_py);
        chk("last_px_act", p_act, 1);
        chk("last_px_x", p_px, 15);
        chk("last_px_y", p_py, 7);
        chk("last_px_x_inv", n_px, 15);
        chk("last_px_y_inv", n_py, 7);
        clk_gen();                       // describes (23,12): front porch
        chk("front_porch_act", p_act, 0);
        chk("front_porch_x", p_px, 0);
        run_to(10, 13);
        clk_gen();
        clk_gen();
        chk("bottom_porch_act", p_act, 0);
        chk("bottom_porch_y", p_py, 0);

        // ---------------- short line while locked ----------------
        run_to(0, 6);
        short_line = 6;
        run_to(0, 7);
        clk_gen();
        $display("short line: hlen=%0d lost=%0d locked=%0d", p_hlen, p_lost, p_locked);
        chk("short_line_hlen", p_hlen, 24);
        chk("short_line_lost", p_lost, 1);
        chk("short_line_locked", p_locked, 0);
        clk_gen();
        chk("short_line_lost_pulse", p_lost, 0);
        run_to(10, 8);
        clk_gen();
        clk_gen();
        chk("unlocked_act", p_act, 0);
        chk("unlocked_x", p_px, 0);
        chk("unlocked_y", p_py, 0);
        run_to(0, 0);
        clk_gen();
        chk("relock1_fs1", p_locked, 0);
        run_to(0, 0);
        clk_gen();
        chk("relock1_fs2", p_locked, 1);

        // ---------------- short frame while locked ----------------
        run_to(0, 3);
        short_frame = 1'b1;
        run_to(0, 0);
        clk_gen();
        $display("short frame: vlen=%0d lost=%0d locked=%0d", p_vlen, p_lost, p_locked);
        chk("short_frame_vlen", p_vlen, 14);
        chk("short_frame_lost", p_lost, 1);
        chk("short_frame_locked", p_locked, 0);
        run_to(0, 0);
        clk_gen();
        chk("after_short_frame_search", p_locked, 0);
        run_to(0, 0);
        clk_gen();
        chk("relock2", p_locked, 1);

        // ---------------- watchdog ----------------
        run_to(0, 4);
        clk_gen();                       // last hs edge
        kill_hs = 1'b1;
        chk("wd_start_locked", p_locked, 1);
        n = 0;
        while (!p_lost && (n < 2200)) begin
            clk_gen();
            n++;
        end
        $display("watchdog: lockLost after %0d cycles, locked=%0d", n, p_locked);
        chk("wd_cycles", n, 2048);
        chk("wd_locked", p_locked, 0);
        run_to(0, 8);
        kill_hs = 1'b0;
        clk_gen();
        chk("wd_hlen_saturated", p_hlen, 2047);
        run_to(0, 0);
        clk_gen();
        chk("relock3_fs1", p_locked, 0);
        run_to(0, 0);
        clk_gen();
        chk("relock3_fs2", p_locked, 1);

        // ---------------- reset mid-frame ----------------
        run_to(10, 7);
        rst_n = 1'b0;
        clk_gen();
        chk_all_zero("mid_reset");
        rst_n = 1'b1;
        run_to(1, 9);
        rst_n = 1'b0;
        clk_gen();                       // hs active during reset
        rst_n = 1'b1;
        clk_gen();                       // hs still active after release
        $display("reset with hs active: hlen=%0d", p_hlen);
        chk("no_false_edge", p_hlen, 0);
        run_to(0, 10);
        clk_gen();
        chk("post_reset_hlen", p_hlen, 24);
        run_to(0, 0);
        clk_gen();
        chk("relock4_fs1", p_locked, 0);
        run_to(0, 0);
        clk_gen();
        chk("relock4_fs2", p_locked, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the team's VGA sync generator. It consumes a horizontal/vertical sync pair, aligns to frame start, checks line and frame lengths against the configured timing, and declares lock after one clean frame. Once locked, it regenerates pixel coordinates and an active-area flag for downstream capture, overlay or checker logic. It sits wherever a VGA-style sync stream enters a design, including loopback from the local generator for self-test.

## Interface
- H_ACTIVE_AREA, 640, active pixels per line
- V_ACTIVE_AREA, 480, active lines per frame
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_SYNC, 96; H_BACK_PORCH, 48; H_FRONT_PORCH, 16; horizontal segment lengths in clocks
- V_SYNC, 2; V_BACK_PORCH, 33; V_FRONT_PORCH, 10; vertical segment lengths in lines
- SYNC_ACTIVE, 1'b1, level of i_hs/i_vs during the sync pulse
- i_clk  in  1  pixel clock; one clock, all logic on its rising edge
- i_reset_n  in  1  reset; synchronous, active-low
- i_hs  in  1  horizontal sync, asserted only during the sync pulse
- i_vs  in  1  vertical sync, asserted only during the sync pulse
- o_locked  out  1  timing verified; coordinate outputs are valid
- o_lockLost  out  1  one-cycle pulse on each LOCKED→SEARCH transition
- o_activeArea  out  1  current pixel lies inside the active window (only while locked)
- o_px  out  10  active-area x coordinate, 0 outside the active area
- o_py  out  10  active-area y coordinate, 0 outside the active area
- o_hLen  out  11  most recently measured line length, in clocks
- o_vLen  out  11  most recently measured frame length, in lines

## Operation
**Edge detection**
- The hs leading edge is i_hs at SYNC_ACTIVE while the previous i_hs sample was inactive.
- The cycle carrying that edge is line position L=0.

**Counters**
- r_hCnt (11 bit) is 0 on the edge cycle and then increments, saturating at 2047.
- Line counter r_lCnt (11 bit) increments on each hs edge and saturates at 2047.

**Frame start**
- A frame start is an hs edge where i_vs is active and i_vs sampled at the previous hs edge was inactive.
- On a frame start, r_lCnt goes to 0.
- vs may lead or lag hs by up to one line minus one clock.

**Measurements**
- At each hs edge, o_hLen <= r_hCnt(prev)+1.
- At each frame start, o_vLen <= r_lCnt(prev)+1.

**FSM**
- SEARCH: on frame start → MEASURE.
- MEASURE:
  - hs edge with line length ≠ H_TOTAL → SEARCH.
  - frame start with frame length = V_TOTAL → LOCKED.
  - frame start with frame length ≠ V_TOTAL → stay in MEASURE; restart the check.
- LOCKED:
  - any line length ≠ H_TOTAL, or frame length ≠ V_TOTAL → SEARCH, and pulse o_lockLost.
- Watchdog, any state: r_hCnt reaching 2047 → SEARCH (o_lockLost pulses if the FSM was LOCKED).
- Simultaneous events: a line-length error takes precedence over a frame-start transition in the same cycle.

**Coordinates**
- Active when L is in [H_SYNC+H_BACK_PORCH, H_TOTAL-H_FRONT_PORCH) and line is in [V_SYNC+V_BACK_PORCH, V_TOTAL-V_FRONT_PORCH), and state is LOCKED.
- o_px = L-(H_SYNC+H_BACK_PORCH) and o_py = line-(V_SYNC+V_BACK_PORCH), truncated to 10 bits.
- Outside the active window, or when not locked: o_px = o_py = 0 and o_activeArea = 0.

## Timing
- Reset value of every output is 0. State = SEARCH, counters = 0.
- Previous-sample flops reset to SYNC_ACTIVE, so no false edge is seen if sync is held active through reset release.
- Reset asserted mid-frame takes effect at the next clock edge. Relock then needs a full SEARCH→MEASURE→LOCKED sequence.
- Coordinate latency is 2 cycles: o_px/o_py/o_activeArea at cycle t+2 describe the input sample at cycle t.
- o_locked and o_lockLost are registered, asserting 1 cycle after the deciding edge.
- o_hLen and o_vLen update 1 cycle after the corresponding edge.
- Lock sequence with a clean stream: o_locked rises 1 cycle after the second frame start seen after reset.

## Structure
- Shared package vga_timing_pkg holds:
  - default 640x480@60 constants, used by both the generator and this block;
  - FSM state encodings SEARCH/MEASURE/LOCKED.
- One sub-module, vga_sync_edge: a parameterised polarity-aware leading-edge detector with its reset level. It is instantiated for hs and for vs.
- Counters, FSM and coordinate pipeline live in the top module.

## Test plan
- Clean 640x480 stream from the sync generator, 3 frames → o_locked rises 1 cycle after frame start #2. o_hLen=800, o_vLen=525. Input (L=144, line 35) gives o_px=0, o_py=0, o_activeArea=1 exactly 2 cycles later; (783, 514) gives o_px=639, o_py=479.
- While locked, one 799-clock line → o_hLen=799, one-cycle o_lockLost, o_locked=0, coordinates forced to 0. Relock after two further frame starts.
- While locked, a 524-line frame → o_vLen=524, o_lockLost pulses, state returns to SEARCH.
- hs held inactive 2100 cycles while locked → o_lockLost when r_hCnt reaches 2047, o_locked=0.
- i_reset_n low for 1 cycle mid-active-area while locked → all outputs 0 the next cycle. i_hs held active across release produces no edge; lock is regained only after two frame starts.
- SYNC_ACTIVE=0 with an inverted clean stream → identical lock timing and coordinates to the first scenario.
